// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encodings, widths and a pattern helper.
package led_seq_pkg;

  localparam int MODE_W = 2;
  localparam int LED_N  = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  // Only the low two step bits select one of the four LEDs.
  function automatic logic [LED_N-1:0] one_hot(input logic [3:0] step);
    return 4'b0001 << step[1:0];
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-tick prescaler: one registered tick every TICK_DIV enabled cycles.
// A synchronous clear restarts the period and swallows any tick due on that edge.
module led_tick_gen #(
  parameter int TICK_DIV = 3000000,
  parameter int CNT_W    = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clr_i || !en_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Five-LED sequencer: mode FSM loaded by a req/ack handshake, stepped by led_tick_gen.
// Optional LED_SEQ_PWM_EN adds a 4-bit brightness input that dims every lit LED.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int   TICK_DIV = 3000000,
  parameter logic LED_ON   = 1'b0,
  parameter int   CNT_W    = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              mode_req,
`ifdef LED_SEQ_PWM_EN
  input  logic [3:0]        bright,
`endif
  output logic              mode_ack,
  output logic              tick,
  output logic              D1,
  output logic              D2,
  output logic              D3,
  output logic              D4,
  output logic              D5
);

  mode_e            mode_q, mode_d;
  logic [3:0]       step_q, step_d;
  logic             dir_q, dir_d;
  logic             hb_q, hb_d;
  logic [LED_N-1:0] pat_q, pat_d;
  logic             ack_q;
  logic [4:0]       pins_q, pins_d;
  logic [4:0]       lit;
  logic             accept;
  logic             tick_w;
  logic             pwm_on;

  // A request held into its own ack cycle is not taken twice.
  assign accept = mode_req && !ack_q;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .clr_i (accept),
    .tick_o(tick_w)
  );

`ifdef LED_SEQ_PWM_EN
  logic [3:0] pwm_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_q <= 4'd0;
    else     pwm_cnt_q <= pwm_cnt_q + 4'd1;
  end

  assign pwm_on = (pwm_cnt_q < bright);
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    dir_d  = dir_q;
    hb_d   = hb_q;
    pat_d  = pat_q;
    if (accept) begin
      mode_d = mode_e'(mode_sel);
      step_d = 4'd0;
      dir_d  = 1'b0;
    end else if (en && tick_w) begin
      // Each tick shows the current step, then advances it.
      case (mode_q)
        MODE_OFF: begin
          pat_d = '0;
          hb_d  = 1'b0;
        end
        MODE_CHASE: begin
          pat_d  = one_hot(step_q);
          step_d = {2'b00, step_q[1:0] + 2'd1};
          hb_d   = ~hb_q;
        end
        MODE_BOUNCE: begin
          pat_d = one_hot(step_q);
          hb_d  = ~hb_q;
          if (!dir_q) begin
            if (step_q == 4'd3) begin
              step_d = 4'd2;
              dir_d  = 1'b1;
            end else begin
              step_d = step_q + 4'd1;
            end
          end else begin
            if (step_q == 4'd0) begin
              step_d = 4'd1;
              dir_d  = 1'b0;
            end else begin
              step_d = step_q - 4'd1;
            end
          end
        end
        default: begin
          pat_d  = step_q;
          step_d = step_q + 4'd1;
          hb_d   = ~hb_q;
        end
      endcase
    end
    lit    = {hb_d, pat_d} & {5{pwm_on}};
    pins_d = en ? (lit ^ {5{~LED_ON}}) : {5{~LED_ON}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_OFF;
      step_q <= 4'd0;
      dir_q  <= 1'b0;
      hb_q   <= 1'b0;
      pat_q  <= '0;
      ack_q  <= 1'b0;
      pins_q <= {5{~LED_ON}};
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      hb_q   <= hb_d;
      pat_q  <= pat_d;
      ack_q  <= accept;
      pins_q <= pins_d;
    end
  end

  assign mode_ack             = ack_q;
  assign tick                 = tick_w;
  assign {D5, D4, D3, D2, D1} = pins_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (TICK_DIV=4, LED_ON=0): a tick-indexed model
// compared every cycle, plus directed literal checks of the mode sequences.
module tb_led_seq_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_req = 1'b0;
  logic       mode_ack, tick, D1, D2, D3, D4, D5;
  logic [4:0] pins;
`ifdef LED_SEQ_PWM_EN
  logic [3:0] bright = 4'd15;
`endif

  int total = 0;
  int bad = 0;
  bit modelOn = 1'b0;

  assign pins = {D5, D4, D3, D2, D1};

  always #5 clk = ~clk;

  led_seq_ctrl #(
    .TICK_DIV(TICK_DIV),
    .LED_ON  (1'b0),
    .CNT_W   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode_sel(mode_sel),
    .mode_req(mode_req),
`ifdef LED_SEQ_PWM_EN
    .bright  (bright),
`endif
    .mode_ack(mode_ack),
    .tick    (tick),
    .D1      (D1),
    .D2      (D2),
    .D3      (D3),
    .D4      (D4),
    .D5      (D5)
  );

  // Model state: the pattern is a function of mode and how many ticks ran since the load.
  int         mCnt = 0;
  int         mIdx = 0;
  int         mMode = 0;
  logic       mTick = 1'b0;
  logic       mAck = 1'b0;
  logic       mHb = 1'b0;
  logic [3:0] mPat = 4'd0;
  logic [4:0] mPins = 5'b11111;

  function automatic logic [3:0] patFor(input int mode, input int idx);
    int p;
    p = idx % 6;
    case (mode)
      1:       return 4'b0001 << (idx % 4);
      2:       return 4'b0001 << ((p <= 3) ? p : 6 - p);
      3:       return 4'(idx % 16);
      default: return 4'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic enV, input logic [1:0] selV, input logic reqV);
    en       = enV;
    mode_sel = selV;
    mode_req = reqV;
  endtask

  task automatic requestMode(input logic [1:0] sel);
    applyStimulus(en, sel, 1'b1);
    @(negedge clk);
    checkOutput("ack pulse", int'(mode_ack), 1);
    mode_req = 1'b0;
  endtask

  task automatic waitTick(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!tick && c < 40);
    if (!tick) begin
      total++;
      bad++;
      $display("[TB] FAIL tick timeout: got no tick in %0d cycles, required one", c);
    end
  endtask

  initial begin : model
    bit acc;
    bit nt;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mCnt = 0; mIdx = 0; mMode = 0; mTick = 1'b0; mAck = 1'b0;
        mHb = 1'b0; mPat = 4'd0; mPins = 5'b11111;
      end else begin
        acc = mode_req && !mAck;
        nt  = 1'b0;
        if (acc || !en) mCnt = 0;
        else if (mCnt == TICK_DIV - 1) begin
          mCnt = 0;
          nt   = 1'b1;
        end else mCnt++;
        if (acc) begin
          mMode = int'(mode_sel);
          mIdx  = 0;
        end else if (en && mTick) begin
          if (mMode == 0) begin
            mPat = 4'd0;
            mHb  = 1'b0;
          end else begin
            mPat = patFor(mMode, mIdx);
            mIdx++;
            mHb = !mHb;
          end
        end
        mPins = en ? ~{mHb, mPat} : 5'b11111;
        mTick = nt;
        mAck  = acc;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (modelOn) begin
        checkOutput("model pins", int'(pins), int'(mPins));
        checkOutput("model ack", int'(mode_ack), int'(mAck));
        checkOutput("model tick", int'(tick), int'(mTick));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int c;
    int nTicks;
    int chaseExp[5]  = '{'b01110, 'b11101, 'b01011, 'b10111, 'b01110};
    int bounceExp[8] = '{'b1110, 'b1101, 'b1011, 'b0111, 'b1011, 'b1101, 'b1110, 'b1101};

    #1 rst = 1'b1;
    modelOn = 1'b1;
    @(negedge clk);
    checkOutput("reset pins", int'(pins), 'b11111);
    checkOutput("reset ack", int'(mode_ack), 0);
    checkOutput("reset tick", int'(tick), 0);
    rst = 1'b0;

    nTicks = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tick) nTicks++;
    end
    checkOutput("disabled ticks", nTicks, 0);
    checkOutput("disabled pins", int'(pins), 'b11111);

    $display("[TB] chase");
    @(negedge clk);
    en = 1'b1;
    requestMode(2'd1);
    for (int k = 0; k < 5; k++) begin
      waitTick(c);
      checkOutput("chase tick gap", (k == 0) ? c : c + 1, TICK_DIV);
      @(negedge clk);
      checkOutput("chase pins", int'(pins), chaseExp[k]);
    end

    $display("[TB] bounce");
    @(negedge clk);
    requestMode(2'd2);
    for (int k = 0; k < 8; k++) begin
      waitTick(c);
      @(negedge clk);
      checkOutput("bounce pins", int'(pins[3:0]), bounceExp[k]);
    end

    $display("[TB] count");
    @(negedge clk);
    requestMode(2'd3);
    for (int k = 0; k < 17; k++) begin
      waitTick(c);
      @(negedge clk);
      checkOutput("count pins", int'(pins[3:0]), (k < 16) ? 15 - k : 15);
    end

    // Land the request on the edge where the next tick would be registered.
    $display("[TB] request/tick collision");
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 2'd3, 1'b1);
    @(negedge clk);
    checkOutput("collide tick", int'(tick), 0);
    checkOutput("collide ack", int'(mode_ack), 1);
    mode_req = 1'b0;
    waitTick(c);
    checkOutput("collide next tick", c, TICK_DIV);
    @(negedge clk);
    checkOutput("collide step zero", int'(pins[3:0]), 15);
    for (int k = 1; k <= 5; k++) begin
      waitTick(c);
      @(negedge clk);
      checkOutput("count resume", int'(pins[3:0]), 15 - k);
    end

    $display("[TB] enable hold");
    en = 1'b0;
    @(negedge clk);
    checkOutput("disable pins", int'(pins), 'b11111);
    nTicks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (tick) nTicks++;
    end
    checkOutput("disable ticks", nTicks, 0);
    en = 1'b1;
    waitTick(c);
    @(negedge clk);
    checkOutput("reenable value", int'(pins[3:0]), 9);

    $display("[TB] reset mid-handshake");
    @(negedge clk);
    applyStimulus(1'b1, 2'd2, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst ack dropped", int'(mode_ack), 0);
    checkOutput("rst pins", int'(pins), 'b11111);
    applyStimulus(1'b1, 2'd0, 1'b0);
    rst = 1'b0;
    waitTick(c);
    @(negedge clk);
    checkOutput("off after reset", int'(pins), 'b11111);
    for (int k = 0; k < 6; k++) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Sequencer that owns the five board LEDs D1..D5 and drives them from a small mode state machine clocked off the 12 MHz board clock.
- A prescaler produces step ticks.
- A req/ack handshake selects one of four display modes: off, chase, bounce, binary count.
- D5 is a heartbeat.
- Sits between top-level control logic (buttons, UART decoder) and the LED pins.

Parameters:
TICK_DIV, 3000000, clk cycles per step tick (≥2); 3000000 gives 4 Hz at 12 MHz
LED_ON, 1'b0, pin level that lights an LED; off level is ~LED_ON
CNT_W, 22, prescaler counter width; must satisfy 2**CNT_W ≥ TICK_DIV

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  run enable; low forces all LEDs off and holds the sequence
mode_sel  input  2  requested mode: 0 OFF, 1 CHASE, 2 BOUNCE, 3 COUNT
mode_req  input  1  request to load mode_sel; level, held until mode_ack
mode_ack  output  1  one-cycle pulse, cycle after mode_req is sampled
tick  output  1  one-cycle step pulse, for observation
D1  output  1  LED 1 (bit 0)
D2  output  1  LED 2 (bit 1)
D3  output  1  LED 3 (bit 2)
D4  output  1  LED 4 (bit 3)
D5  output  1  heartbeat LED

Behaviour:
- Reset (async assert, sync release):
  - mode=OFF, step=0, dir=up, hb=0, prescaler=0, mode_ack=0, tick=0.
  - D1..D5 = ~LED_ON.
- Prescaler:
  - When en=1, counts 0..TICK_DIV-1 and wraps.
  - tick=1 registered on the cycle the count wraps, giving one tick every TICK_DIV cycles. First tick after reset/enable comes TICK_DIV cycles later.
  - When en=0, count is held at 0 and tick=0.
- Handshake:
  - mode_req=1 on edge N (with mode_ack=0): mode←mode_sel, step←0, dir←up, prescaler←0 at edge N. mode_ack=1 for cycle N+1 only.
  - Requester must drop mode_req in the ack cycle. A req still high the cycle after ack counts as a new request.
  - Req is accepted regardless of en.
- Simultaneous request and tick: request wins; that tick is discarded (tick output stays 0).
- Per-tick updates (en=1), pattern L[3:0] on D4..D1:
  - OFF: L=0000, hb=0, step held.
  - CHASE: step 0→1→2→3→0; L = one-hot(step).
  - BOUNCE: step 0,1,2,3,2,1,0,1…; dir flips at 3 and at 0, so the endpoints are not repeated. L = one-hot(step).
  - COUNT: 4-bit step counts 0..15 and wraps to 0; L=step (D1 LSB).
  - D5: hb toggles each tick in non-OFF modes.
- Output mapping: Dk = LED_ON when lit, else ~LED_ON. All outputs registered; pattern visible the cycle after the tick.
- en=0 mid-sequence: all LEDs off next cycle; step/dir/hb retained. Resume continues from the retained step after TICK_DIV cycles.
- Reset mid-handshake: pending ack is dropped, mode=OFF.

Optional Feature:
LED_SEQ_PWM_EN
- Defined:
  - Adds input bright [3:0] and an internal 4-bit free-running PWM counter.
  - A lit LED is driven LED_ON only while pwm_cnt < bright, otherwise ~LED_ON.
  - bright=15 gives 15/16 duty; bright=0 keeps everything off.
  - D5 is also dimmed.
- Undefined: no bright port; lit LEDs are driven constantly.

Decomposition:
- Package/header led_seq_pkg holds:
  - mode encodings MODE_OFF, MODE_CHASE, MODE_BOUNCE, MODE_COUNT;
  - MODE_W=2;
  - LED_N=4.
- Sub-module led_tick_gen (TICK_DIV, CNT_W): prescaler with en and sync clear (clr) inputs, tick output. Used by the sequencer.

Test Plan:
1. Reset with TICK_DIV=4, LED_ON=0 → D1..D5=1, mode_ack=0, tick=0; hold en=0 for 20 cycles → outputs unchanged, no ticks.
2. en=1, req CHASE → ack exactly 1 cycle later; lit LED sequence D1,D2,D3,D4,D1 on consecutive ticks 4 cycles apart; D5 toggles each tick.
3. req BOUNCE, run 8 ticks → lit sequence D1,D2,D3,D4,D3,D2,D1,D2.
4. req COUNT, run 17 ticks → {D4..D1} shows ~(0..15) then ~0, confirming wrap 15→0.
5. Assert req on the same cycle a tick is due → no tick pulse; step=0; next tick comes 4 cycles after the request edge. Deassert en mid-COUNT at step 5 → all off; re-enable → next value 6.
6. LED_SEQ_PWM_EN, bright=4, CHASE → lit LED low for 4 of every 16 cycles; bright=0 → all high.
